rr_arbiter: RTL and testbench

//  Round-robin arbiter with lock-until-release grants. Takes a request vector, rotates
//  it by the last winner, and applies an LSB-first find-first-set to produce a registered
//  one-hot grant plus its binary index. Sits directly upstream of one-hot consumers
//  (mux selects, shared-port steering) as the stateful companion of the

---
 rtl/rr_arbiter.sv | 118 +++++++++++
 tb/tb_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with lock-until-release grants and registered one-hot output.
// Optional hold timeout enabled by defining RR_ARB_TIMEOUT_EN (uses MAX_HOLD).
module rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 grant_vld
);

   localparam int IW = $clog2(N);

   typedef enum logic {IDLE, GRANT} state_t;

   if (N < 2 || MAX_HOLD < 1) begin : g_bad_cfg
      $error("rr_arbiter: need N >= 2 and MAX_HOLD >= 1");
   end

   state_t         state_q, state_d;
   logic [N-1:0]   grant_d;
   logic [IW-1:0]  idx_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [N-1:0]   masked;
   logic [IW-1:0]  win;
   logic           timeout;

`ifdef RR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0]  cnt_q, cnt_d;

   // Count grant cycles; clear on entry to GRANT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Expire on the last allowed cycle so the grant lasts exactly MAX_HOLD cycles
   always_comb begin
      timeout = (state_q == GRANT) && (cnt_q == CW'(MAX_HOLD - 1));
      cnt_d   = cnt_q;
      if (state_q == IDLE)  cnt_d = '0;
      else if (!timeout)    cnt_d = cnt_q + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   // Rotate priority: first set bit above last winner, else wrap to lowest set bit
   always_comb begin
      logic found;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < N; i++)
         masked[i] = req[i] && (i > int'(ptr_q));
      for (int i = 0; i < N; i++) begin
         if (!found && masked[i]) begin
            win   = IW'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            win   = IW'(i);
            found = 1'b1;
         end
      end
   end

   // State and grant registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         ptr_q     <= IW'(N - 1);
      end else begin
         state_q   <= state_d;
         grant     <= grant_d;
         grant_idx <= idx_d;
         ptr_q     <= ptr_d;
      end
   end

   // Next-state: arbitrate in IDLE, hold in GRANT until release or timeout
   always_comb begin
      state_d = state_q;
      grant_d = grant;
      idx_d   = grant_idx;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            idx_d   = '0;
            if (|req) begin
               grant_d[win] = 1'b1;
               idx_d        = win;
               ptr_d        = win;
               state_d      = GRANT;
            end
         end
         GRANT: begin
            if (!req[grant_idx] || timeout) begin
               grant_d = '0;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_vld = |grant;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (N=4, MAX_HOLD=8).
// Timeout scenario runs only when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_vld;

   int n_chk;
   int n_fail;

   rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] r);
      rst_n = 1'b0;
      req   = r;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk(input string nm, input logic [3:0] g, input logic [1:0] ix, input logic v);
      n_chk++;
      if (grant !== g || grant_idx !== ix || grant_vld !== v) begin
         n_fail++;
         $display("FAIL %s: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
                  nm, grant, grant_idx, grant_vld, g, ix, v);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      #1;
      chk("reset_async", 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_hold", 4'b0000, 2'd0, 1'b0);
      end
      rst_n = 1'b1;
      tick();
      chk("reset_first_grant", 4'b0001, 2'd0, 1'b1);
   endtask

   task automatic test_hold();
      do_reset(4'b0000);
      tick();
      chk("idle_zero", 4'b0000, 2'd0, 1'b0);
      req = 4'b0101;
      tick();
      chk("hold_first", 4'b0001, 2'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         req[3] = ~req[3];
         tick();
         chk("hold_ignore_others", 4'b0001, 2'd0, 1'b1);
      end
      req = 4'b0100;
      tick();
      chk("release_gap", 4'b0000, 2'd0, 1'b0);
      tick();
      chk("release_next", 4'b0100, 2'd2, 1'b1);
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g [5];
      logic [1:0] exp_i [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset(4'b1111);
      for (int k = 0; k < 5; k++) begin
         req = 4'b1111;
         tick();
         chk("rot_grant_c1", exp_g[k], exp_i[k], 1'b1);
         tick();
         chk("rot_grant_c2", exp_g[k], exp_i[k], 1'b1);
         req = 4'b1111 & ~exp_g[k];
         tick();
         chk("rot_gap", 4'b0000, 2'd0, 1'b0);
      end
   endtask

   task automatic test_single_requester();
      do_reset(4'b0000);
      req = 4'b0100;
      tick();
      chk("single_first", 4'b0100, 2'd2, 1'b1);
      req = 4'b0000;
      tick();
      chk("single_gap", 4'b0000, 2'd0, 1'b0);
      req = 4'b0100;
      tick();
      chk("single_regrant", 4'b0100, 2'd2, 1'b1);
   endtask

   task automatic test_reset_mid();
      do_reset(4'b0100);
      tick();
      chk("mid_pre", 4'b0100, 2'd2, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_async_drop", 4'b0000, 2'd0, 1'b0);
      req = 4'b1111;
      tick();
      rst_n = 1'b1;
      chk("mid_still_idle", 4'b0000, 2'd0, 1'b0);
      tick();
      chk("mid_after", 4'b0001, 2'd0, 1'b1);
   endtask

`ifdef RR_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset(4'b0011);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("to_grant0", 4'b0001, 2'd0, 1'b1);
      end
      tick();
      chk("to_gap0", 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("to_grant1", 4'b0010, 2'd1, 1'b1);
      end
      tick();
      chk("to_gap1", 4'b0000, 2'd0, 1'b0);
      tick();
      chk("to_back0", 4'b0001, 2'd0, 1'b1);
   endtask
`else
   task automatic test_no_timeout();
      do_reset(4'b0011);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_forever", 4'b0001, 2'd0, 1'b1);
      end
   endtask
`endif

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      req    = 4'b0000;
      test_reset();
      test_hold();
      test_rotation();
      test_single_requester();
      test_reset_mid();
`ifdef RR_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
